// File: rtl/mmu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmu_arb_pkg
// Purpose : Shared encodings for the MMU CPU-port arbiter: FSM state codes
//           and requester identifiers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mmu_arb_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Requester identifiers
  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

endpackage : mmu_arb_pkg
`default_nettype wire

// File: rtl/mmu_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr2
// Purpose : Combinational 2-way picker. A lone requester always wins; on a
//           tie, r0 wins under fixed priority, otherwise whichever requester
//           did not win last time.
// Ports   : req[1:0]        requests, bit 0 = r0, bit 1 = r1
//           last_grant      id of the previous winner
//           fixed_priority  1 = r0 always wins a tie
//           grant_valid     at least one request present
//           grant_id        id of the winner (valid with grant_valid)
// Rev     : 1.0  initial release
// ============================================================================
module arb_rr2
  import mmu_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_priority,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_R0;
    if (req == 2'b11) begin
      grant_id = fixed_priority ? REQ_R0 : ~last_grant;
    end else if (req[1]) begin
      grant_id = REQ_R1;
    end
  end

endmodule : arb_rr2
`default_nettype wire

// File: rtl/mmu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mmu_arbiter
// Purpose : Shares the MMU CPU-side port between the pipeline Memory stage
//           (r0) and a secondary master (r1). Runs the IDLE -> BUSY -> DONE
//           handshake with the MMU, aborts after TIMEOUT cycles without
//           c_data_ready, and stalls the pipeline while r0 waits.
// Ports   : clock, reset (async, active low)
//           r0_* / r1_*  requester side: req, address, data_in, write_enable,
//                        done, data_out, error (+ r0_stall)
//           c_*          MMU side: address, data_in, write_enable, valid,
//                        data_ready, data_out
// Rev     : 1.0  initial release
// ============================================================================
module mmu_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned R0_PRIORITY = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_data_in,
  input  logic              r0_write_enable,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_data_out,
  output logic              r0_stall,
  output logic              r0_error,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_data_in,
  input  logic              r1_write_enable,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_data_out,
  output logic              r1_error,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_data_in,
  output logic              c_write_enable,
  output logic              c_valid,
  input  logic              c_data_ready,
  input  logic [DATA_W-1:0] c_data_out
);

  // Timer value on the last BUSY cycle before giving up
  localparam logic [7:0] C_TIMER_LAST  = 8'(TIMEOUT - 1);
  localparam logic       C_FIXED_PRIO  = (R0_PRIORITY != 0);

  logic [1:0]        r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic              r_err;
  logic [7:0]        r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_r0_rdata;
  logic [DATA_W-1:0] r_r1_rdata;

  logic              w_grant_valid;
  logic              w_grant_id;
  logic              w_busy;
  logic              w_done;
  logic              w_finish;
  logic [DATA_W-1:0] w_capture;

  arb_rr2 u_arb (
    .req            ({r1_req, r0_req}),
    .last_grant     (r_last_grant),
    .fixed_priority (C_FIXED_PRIO),
    .grant_valid    (w_grant_valid),
    .grant_id       (w_grant_id)
  );

  assign w_busy   = (r_state == BUSY);
  assign w_done   = (r_state == DONE);
  assign w_finish = c_data_ready || (r_timer == C_TIMER_LAST);

  // Writes and timeouts both return zero data
  assign w_capture = (c_data_ready && !r_we) ? c_data_out : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= REQ_R0;
      r_last_grant <= REQ_R1;   // r0 wins the first tie after reset
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_timer      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_r0_rdata   <= '0;
      r_r1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_addr       <= (w_grant_id == REQ_R1) ? r1_address      : r0_address;
            r_wdata      <= (w_grant_id == REQ_R1) ? r1_data_in      : r0_data_in;
            r_we         <= (w_grant_id == REQ_R1) ? r1_write_enable : r0_write_enable;
            r_timer      <= '0;
            r_err        <= 1'b0;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          r_timer <= r_timer + 8'd1;
          if (w_finish) begin
            // Ready wins over a coincident timeout
            r_err <= !c_data_ready;
            if (r_owner == REQ_R1) r_r1_rdata <= w_capture;
            else                   r_r0_rdata <= w_capture;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // MMU side: only driven while a transaction is in flight
  assign c_valid        = w_busy;
  assign c_write_enable = w_busy & r_we;
  assign c_address      = w_busy ? r_addr  : '0;
  assign c_data_in      = w_busy ? r_wdata : '0;

  // Requester side
  assign r0_done     = w_done & (r_owner == REQ_R0);
  assign r1_done     = w_done & (r_owner == REQ_R1);
  assign r0_error    = r0_done & r_err;
  assign r1_error    = r1_done & r_err;
  assign r0_data_out = r_r0_rdata;
  assign r1_data_out = r_r1_rdata;
  assign r0_stall    = r0_req & ~r0_done;

endmodule : mmu_arbiter
`default_nettype wire

// File: tb/tb_mmu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmu_arbiter
// Purpose : Self-checking bench for mmu_arbiter. A queue holds the expected
//           completion (owner, data, error) of every transaction issued; a
//           monitor pops and compares on each done pulse. A second instance
//           with R0_PRIORITY=1 covers fixed priority.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mmu_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          r0_req, r0_write_enable, r0_done, r0_stall, r0_error;
  logic [AW-1:0] r0_address;
  logic [DW-1:0] r0_data_in, r0_data_out;
  logic          r1_req, r1_write_enable, r1_done, r1_error;
  logic [AW-1:0] r1_address;
  logic [DW-1:0] r1_data_in, r1_data_out;
  logic [AW-1:0] c_address;
  logic [DW-1:0] c_data_in, c_data_out;
  logic          c_write_enable, c_valid, c_data_ready;

  // MMU model: ready after ready_delay BUSY cycles, read data = address + 39
  int ready_delay;
  int vcnt;
  always @(posedge clock) vcnt <= c_valid ? vcnt + 1 : 0;
  assign c_data_ready = c_valid && (vcnt == ready_delay);
  assign c_data_out   = c_address + 32'd39;

  mmu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15), .R0_PRIORITY(0)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_address(r0_address), .r0_data_in(r0_data_in),
    .r0_write_enable(r0_write_enable), .r0_done(r0_done), .r0_data_out(r0_data_out),
    .r0_stall(r0_stall), .r0_error(r0_error),
    .r1_req(r1_req), .r1_address(r1_address), .r1_data_in(r1_data_in),
    .r1_write_enable(r1_write_enable), .r1_done(r1_done), .r1_data_out(r1_data_out),
    .r1_error(r1_error),
    .c_address(c_address), .c_data_in(c_data_in), .c_write_enable(c_write_enable),
    .c_valid(c_valid), .c_data_ready(c_data_ready), .c_data_out(c_data_out)
  );

  // Fixed-priority instance, MMU always ready immediately
  logic          p_r0_req, p_r0_done, p_r0_stall, p_r0_error;
  logic          p_r1_req, p_r1_done, p_r1_error;
  logic [DW-1:0] p_r0_data_out, p_r1_data_out, p_c_data_in, p_c_data_out;
  logic [AW-1:0] p_c_address;
  logic          p_c_write_enable, p_c_valid, p_c_data_ready;
  assign p_c_data_ready = p_c_valid;
  assign p_c_data_out   = p_c_address + 32'd39;

  mmu_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15), .R0_PRIORITY(1)) dut_p (
    .clock(clock), .reset(reset),
    .r0_req(p_r0_req), .r0_address(32'h11), .r0_data_in(32'h0),
    .r0_write_enable(1'b0), .r0_done(p_r0_done), .r0_data_out(p_r0_data_out),
    .r0_stall(p_r0_stall), .r0_error(p_r0_error),
    .r1_req(p_r1_req), .r1_address(32'h22), .r1_data_in(32'h0),
    .r1_write_enable(1'b0), .r1_done(p_r1_done), .r1_data_out(p_r1_data_out),
    .r1_error(p_r1_error),
    .c_address(p_c_address), .c_data_in(p_c_data_in), .c_write_enable(p_c_write_enable),
    .c_valid(p_c_valid), .c_data_ready(p_c_data_ready), .c_data_out(p_c_data_out)
  );

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   model_last = 1'b1;

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t          e;
    logic          id;
    logic [DW-1:0] d;
    logic          er;
    if (r0_done || r1_done) begin
      n_tests++;
      id = r1_done;
      d  = r1_done ? r1_data_out : r0_data_out;
      er = r1_done ? r1_error    : r0_error;
      if (r0_done && r1_done) begin
        $display("FAIL sb_both_done: r0_done=1 r1_done=1, want only one");
        n_fail++;
      end else if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: done id=%0d data=%h, want no completion", id, d);
        n_fail++;
      end else begin
        e = sb.pop_front();
        if ({id, d, er} !== {e.id, e.data, e.err}) begin
          $display("FAIL sb_done: got id=%0d data=%h err=%0d, want id=%0d data=%h err=%0d",
                   id, d, er, e.id, e.data, e.err);
          n_fail++;
        end
      end
    end
  end

  // One transaction on the main instance; returns observed BUSY statistics
  task automatic run_txn(input bit id, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit we, input int delay, input logic [DW-1:0] exp_data,
                         input bit exp_err, output int vcyc, output int wcyc,
                         output int stall_bad, output int bus_bad);
    bit done;
    ready_delay = delay;
    vcyc = 0; wcyc = 0; stall_bad = 0; bus_bad = 0; done = 0;
    sb.push_back(exp_t'{id: id, data: exp_data, err: exp_err});
    if (id) begin
      r1_req = 1; r1_address = addr; r1_data_in = wdata; r1_write_enable = we;
    end else begin
      r0_req = 1; r0_address = addr; r0_data_in = wdata; r0_write_enable = we;
    end
    #1;
    if (!id && r0_stall !== 1'b1) stall_bad++;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (id ? r1_done : r0_done) begin
        done = 1;
        if (!id && r0_stall !== 1'b0) stall_bad++;
        if (id) r1_req = 0; else r0_req = 0;
      end else begin
        if (c_valid) begin
          vcyc++;
          if (c_address !== addr || c_data_in !== wdata) bus_bad++;
        end
        if (c_write_enable) wcyc++;
        if (!id && r0_stall !== 1'b1) stall_bad++;
      end
    end
    n_tests++;
    if (!done) begin
      $display("FAIL txn_timeout: no done for id=%0d within 40 cycles", id);
      n_fail++;
    end
    model_last = id;
  endtask

  task automatic test_reset();
    reset = 0;
    r0_req = 0; r0_address = '0; r0_data_in = '0; r0_write_enable = 0;
    r1_req = 0; r1_address = '0; r1_data_in = '0; r1_write_enable = 0;
    p_r0_req = 0; p_r1_req = 0;
    ready_delay = 0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({r0_done, r0_error, r0_stall, r0_data_out, r1_done, r1_error, r1_data_out} !== '0) begin
      $display("FAIL reset_req_outputs: got %h, want 0",
               {r0_done, r0_error, r0_stall, r0_data_out, r1_done, r1_error, r1_data_out});
      n_fail++;
    end
    n_tests++;
    if ({c_valid, c_write_enable, c_address, c_data_in} !== '0) begin
      $display("FAIL reset_mmu_outputs: got %h, want 0",
               {c_valid, c_write_enable, c_address, c_data_in});
      n_fail++;
    end
    reset = 1;
    @(negedge clock);
    n_tests++;
    if (c_valid !== 1'b0) begin
      $display("FAIL reset_idle: c_valid=%b, want 0", c_valid);
      n_fail++;
    end
  endtask

  // Both request right after reset: r0 must win the first tie
  task automatic test_first_tie();
    int  t0, t1, first;
    bit  d0, d1;
    ready_delay = 0;
    t0 = -1; t1 = -1; first = -1; d0 = 0; d1 = 0;
    sb.push_back(exp_t'{id: 1'b0, data: 32'h10 + 32'd39, err: 1'b0});
    sb.push_back(exp_t'{id: 1'b1, data: 32'h20 + 32'd39, err: 1'b0});
    r0_address = 32'h10; r1_address = 32'h20;
    r0_req = 1; r1_req = 1;
    for (int i = 0; i < 20 && !(d0 && d1); i++) begin
      @(negedge clock);
      if (r0_done) begin d0 = 1; t0 = i; r0_req = 0; if (first < 0) first = 0; end
      if (r1_done) begin d1 = 1; t1 = i; r1_req = 0; if (first < 0) first = 1; end
    end
    n_tests++;
    if (first !== 0) begin
      $display("FAIL first_tie_winner: got %0d, want 0", first);
      n_fail++;
    end
    n_tests++;
    if (t1 - t0 !== 3) begin
      $display("FAIL first_tie_spacing: got %0d, want 3", t1 - t0);
      n_fail++;
    end
    model_last = 1;
  endtask

  task automatic test_single_read();
    int vc, wc, sbad, bbad;
    @(negedge clock);
    run_txn(0, 32'd3, 32'd0, 0, 1, 32'd42, 0, vc, wc, sbad, bbad);
    n_tests++;
    if (vc !== 2) begin
      $display("FAIL read_valid_cycles: got %0d, want 2", vc);
      n_fail++;
    end
    n_tests++;
    if (sbad !== 0) begin
      $display("FAIL read_stall: %0d bad cycles, want 0", sbad);
      n_fail++;
    end
    @(negedge clock);
    n_tests++;
    if (r0_data_out !== 32'd42 || r0_stall !== 1'b0) begin
      $display("FAIL read_hold: data=%0d stall=%b, want 42 and 0", r0_data_out, r0_stall);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int vc, wc, sbad, bbad;
    @(negedge clock);
    run_txn(1, 32'h100, 32'hDEAD, 1, 255, 32'd0, 1, vc, wc, sbad, bbad);
    n_tests++;
    if (vc !== 15 || wc !== 15) begin
      $display("FAIL timeout_cycles: valid=%0d we=%0d, want 15 and 15", vc, wc);
      n_fail++;
    end
    n_tests++;
    if (bbad !== 0) begin
      $display("FAIL timeout_bus: %0d bad address/data cycles, want 0", bbad);
      n_fail++;
    end
  endtask

  task automatic test_addr_hold();
    int  bad, vc;
    bit  done;
    @(negedge clock);
    ready_delay = 4;
    bad = 0; vc = 0; done = 0;
    sb.push_back(exp_t'{id: 1'b0, data: 32'd42, err: 1'b0});
    r0_req = 1; r0_address = 32'd3; r0_write_enable = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (r0_done) begin
        done = 1; r0_req = 0;
      end else if (c_valid) begin
        vc++;
        if (c_address !== 32'd3) bad++;
        r0_address = 32'd7;
      end
    end
    n_tests++;
    if (bad !== 0 || vc !== 5 || !done) begin
      $display("FAIL addr_hold: bad=%0d valid=%0d done=%b, want 0, 5, 1", bad, vc, done);
      n_fail++;
    end
    model_last = 0;
  endtask

  task automatic test_round_robin();
    int  cnt, last_t, bad_gap;
    bit  id;
    @(negedge clock);
    ready_delay = 0;
    id = ~model_last;
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_t'{id: id, data: (id ? 32'h80 : 32'h40) + 32'd39, err: 1'b0});
      id = ~id;
    end
    r0_address = 32'h40; r1_address = 32'h80;
    r0_write_enable = 0; r1_write_enable = 0;
    r0_req = 1; r1_req = 1;
    cnt = 0; last_t = -1; bad_gap = 0;
    for (int i = 0; i < 60 && cnt < 6; i++) begin
      @(negedge clock);
      if (r0_done || r1_done) begin
        if (last_t >= 0 && i - last_t != 3) bad_gap++;
        last_t = i;
        cnt++;
        if (cnt == 6) begin r0_req = 0; r1_req = 0; end
      end
    end
    n_tests++;
    if (cnt !== 6 || bad_gap !== 0) begin
      $display("FAIL rr_dones: count=%0d bad_gaps=%0d, want 6 and 0", cnt, bad_gap);
      n_fail++;
    end
    model_last = model_last;  // six alternating grants end on the same id as before
  endtask

  task automatic test_priority();
    int c0, c1;
    bit got1;
    @(negedge clock);
    p_r0_req = 1; p_r1_req = 1;
    c0 = 0; c1 = 0; got1 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (p_r0_done) c0++;
      if (p_r1_done) c1++;
    end
    p_r0_req = 0;
    n_tests++;
    if (c0 !== 4 || c1 !== 0) begin
      $display("FAIL prio_counts: r0=%0d r1=%0d, want 4 and 0", c0, c1);
      n_fail++;
    end
    n_tests++;
    if (p_r0_data_out !== 32'h11 + 32'd39) begin
      $display("FAIL prio_r0_data: got %h, want %h", p_r0_data_out, 32'h11 + 32'd39);
      n_fail++;
    end
    for (int i = 0; i < 6 && !got1; i++) begin
      @(negedge clock);
      if (p_r1_done) begin got1 = 1; p_r1_req = 0; end
    end
    p_r1_req = 0;
    n_tests++;
    if (!got1 || p_r1_data_out !== 32'h22 + 32'd39) begin
      $display("FAIL prio_r1_after: done=%b data=%h, want 1 and %h", got1, p_r1_data_out,
               32'h22 + 32'd39);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_busy();
    bit seen, got;
    int t;
    @(negedge clock);
    ready_delay = 255;
    r0_req = 1; r0_address = 32'h5; r0_write_enable = 0;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clock);
      if (c_valid) seen = 1;
    end
    repeat (2) @(negedge clock);
    reset = 0;
    r0_req = 0;
    r1_req = 1; r1_address = 32'h200; r1_write_enable = 0;
    #1;
    n_tests++;
    if (!seen || {c_valid, c_write_enable, c_address, c_data_in} !== '0) begin
      $display("FAIL rst_busy_mmu: seen=%b outputs=%h, want seen=1 outputs 0", seen,
               {c_valid, c_write_enable, c_address, c_data_in});
      n_fail++;
    end
    n_tests++;
    if ({r0_done, r0_error, r0_stall, r0_data_out, r1_done, r1_error, r1_data_out} !== '0) begin
      $display("FAIL rst_busy_req: outputs=%h, want 0",
               {r0_done, r0_error, r0_stall, r0_data_out, r1_done, r1_error, r1_data_out});
      n_fail++;
    end
    repeat (2) @(negedge clock);
    n_tests++;
    if (c_valid !== 1'b0) begin
      $display("FAIL rst_busy_hold: c_valid=%b, want 0", c_valid);
      n_fail++;
    end
    reset = 1;
    ready_delay = 0;
    sb.push_back(exp_t'{id: 1'b1, data: 32'h200 + 32'd39, err: 1'b0});
    got = 0; t = -1;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clock);
      if (r1_done) begin got = 1; t = i; r1_req = 0; end
    end
    r1_req = 0;
    n_tests++;
    if (t !== 2) begin
      $display("FAIL rst_r1_grant: r1 done at cycle %0d after release, want 2", t);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_first_tie();
    test_single_read();
    test_timeout();
    test_addr_hold();
    test_round_robin();
    test_priority();
    test_reset_mid_busy();
    repeat (3) @(negedge clock);
    n_tests++;
    if (sb.size() !== 0) begin
      $display("FAIL sb_leftover: %0d completions outstanding, want 0", sb.size());
      n_fail++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mmu_arbiter
`default_nettype wire

// File: doc/mmu_arbiter.md
Name: mmu_arbiter

Overview:
- Shares the single CPU-side port of the MMU (RAM plus peripheral window) between two requesters: r0 is the pipeline Memory stage and r1 is a secondary master, such as a debug/program loader or DMA.
- Sits between the cpu Memory stage and MMU inputs c_address/c_data_in/c_write_enable.
- Owns the transaction handshake with the MMU, including waiting on c_data_ready.
- Raises a pipeline stall while r0 waits.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, max cycles to wait for c_data_ready before aborting (1..255).
- R0_PRIORITY, 0, 1 = r0 always wins contention; 0 = round-robin.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  Memory-stage request, held high until r0_done.
- r0_address  in  ADDR_W  r0 address.
- r0_data_in  in  DATA_W  r0 write data.
- r0_write_enable  in  1  r0 write (1) or read (0).
- r0_done  out  1  one-cycle completion pulse for r0.
- r0_data_out  out  DATA_W  r0 read data, valid with r0_done.
- r0_stall  out  1  high while r0_req is high and r0_done is not asserted.
- r1_req, r1_address, r1_data_in, r1_write_enable, r1_done, r1_data_out  (same semantics as r0).
- r1_error  out  1  pulses with r1_done if the transaction timed out.
- r0_error  out  1  pulses with r0_done if the transaction timed out.
- c_address  out  ADDR_W  to MMU.
- c_data_in  out  DATA_W  to MMU.
- c_write_enable  out  1  to MMU, high only in the BUSY state of a write.
- c_valid  out  1  to MMU, high for the whole BUSY state.
- c_data_ready  in  1  MMU completion.
- c_data_out  in  DATA_W  MMU read data.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and last_grant goes to 1, so r0 wins the first tie.
  - All outputs are 0 and the timer is 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If no request, stay in IDLE.
  - If one request, grant it.
  - If both request: with R0_PRIORITY=1, grant r0. Otherwise grant the requester that is not last_grant.
  - On a grant: latch owner, address, data and write_enable into registers; set last_grant=owner; load timer=0; go to BUSY on the next edge.
- BUSY:
  - c_valid=1. c_address, c_data_in and c_write_enable are driven from the latched registers, so requester changes are ignored.
  - Timer increments each cycle.
  - If c_data_ready=1: capture c_data_out (reads; 0 for writes) and go to DONE.
  - Else, if timer==TIMEOUT-1: capture 0, set err, and go to DONE.
- DONE:
  - Lasts exactly one cycle. The owner's rX_done=1, rX_data_out holds the captured data, and rX_error=err.
  - The non-owner's done is 0.
  - Then go to IDLE.
  - A new request can be granted in the cycle after DONE. Minimum occupancy is 3 cycles per transaction (grant edge, BUSY, DONE).
- rX_data_out holds its last captured value until the next completion for that requester.
- r0_stall is combinational: r0_req & ~r0_done. It is asserted on the same cycle r0_req rises.
- Requester contract: a requester deasserts req in the cycle after done. Keeping req high issues a new transaction.
- A request dropped while waiting is never granted. A request dropped while BUSY still completes, with done issued.
- If c_data_ready is asserted in IDLE or DONE, it is ignored.
- Reset asserted mid-BUSY: abort immediately. No done pulse is issued and all outputs return to 0.

Decomposition:
- Shared package mmu_arb_pkg:
  - State encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Requester IDs: REQ_R0=1'b0, REQ_R1=1'b1.
- Natural sub-module: arb_rr2, the combinational 2-way round-robin/priority picker.
  - Inputs: req[1:0], last_grant, fixed_priority.
  - Outputs: grant_valid, grant_id.

Test Plan:
1. r0 read, addr 3, MMU returns 42 with c_data_ready one cycle after c_valid rises -> c_valid high for 2 cycles; r0_done pulses once with r0_data_out=42 and r0_error=0; r0_stall is high from the req cycle through the cycle before done.
2. r0 and r1 requesting continuously, R0_PRIORITY=0, MMU ready immediately -> grants alternate r0,r1,r0,r1; each done occurs 3 cycles apart.
3. Same as scenario 2 with R0_PRIORITY=1 -> r0 gets every grant; r1_done never asserts while r0_req is held.
4. r1 write to addr 0x100 data 0xDEAD, c_data_ready never asserted, TIMEOUT=15 -> c_valid high exactly 15 cycles; c_write_enable=1 throughout; r1_done=1 with r1_error=1 and r1_data_out=0.
5. Change r0_address from 3 to 7 mid-BUSY -> c_address stays 3 until DONE.
6. Assert reset low mid-BUSY and release 2 cycles later -> all outputs 0 immediately; no done pulse; a pending r1_req is granted first after reset because last_grant=1 and R0_PRIORITY=0 only matter when both request.
